// File: rtl/translate_seq.sv
// Y86/MIPS micro-op translator: expands pushl/popl/call/ret into two micro-ops and buffers them in a FIFO.
// Optional macro TRANSLATE_SEQ_BYPASS_EN lets the incoming micro-op skip an empty queue in the same cycle.
module translate_seq #(
    parameter int          DEPTH  = 4,
    parameter logic [4:0]  SP_REG = 5'd4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [47:0] inst,
    input  logic [31:0] next_inst_pc,
    input  logic [54:0] in_uop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [54:0] out_uop,
    output logic        out_last,
    output logic [4:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0101;

    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;
    localparam logic [3:0] IC_PUSH = 4'hA;
    localparam logic [3:0] IC_POP  = 4'hB;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rn;
        logic [31:0] imm;
        logic        m2reg;
        logic        wmem;
        logic        wreg;
        logic        useimm;
    } uop_t;

    typedef enum logic {IDLE, EXP} state_t;

    state_t             r_state;
    uop_t               r_u1;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [4:0]         r_count;
    logic [55:0]        r_mem [DEPTH];

    uop_t               w_u0;
    uop_t               w_u1;
    logic               w_expand;
    logic [4:0]         w_ra_reg;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    uop_t               w_push_uop;
    logic               w_push_last;
    logic               w_bypass;
    logic               w_bypass_take;
    logic               w_unused;

    function automatic uop_t mk_uop(input logic [3:0] aluc, input logic [4:0] ra,
                                    input logic [4:0] rb, input logic [4:0] rn,
                                    input logic [31:0] imm, input logic m2reg,
                                    input logic wmem, input logic wreg);
        return '{aluc: aluc, ra: ra, rb: rb, rn: rn, imm: imm,
                 m2reg: m2reg, wmem: wmem, wreg: wreg, useimm: 1'b1};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_ra_reg = {1'b0, inst[15:12]};
    assign w_unused = ^{inst[47:16], inst[11:8], inst[3:0]};

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_u0     = uop_t'(in_uop);
        w_u1     = '0;
        w_expand = 1'b0;
        if (mode) begin
            case (inst[7:4])
                IC_PUSH: begin
                    w_expand = 1'b1;
                    w_u0 = mk_uop(ALU_ADD, SP_REG, 5'd0, SP_REG, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
                    w_u1 = mk_uop(ALU_ADD, SP_REG, w_ra_reg, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
                end
                IC_POP: begin
                    w_expand = 1'b1;
                    w_u0 = mk_uop(ALU_ADD, SP_REG, 5'd0, w_ra_reg, 32'd0, 1'b1, 1'b0, 1'b1);
                    w_u1 = mk_uop(ALU_ADD, SP_REG, 5'd0, SP_REG, 32'd4, 1'b0, 1'b0, 1'b1);
                end
                IC_CALL: begin
                    w_expand = 1'b1;
                    w_u0 = mk_uop(ALU_ADD, SP_REG, 5'd0, SP_REG, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
                    w_u1 = mk_uop(ALU_OR, 5'd0, SP_REG, 5'd0, next_inst_pc, 1'b0, 1'b1, 1'b0);
                end
                IC_RET: begin
                    w_expand = 1'b1;
                    w_u0 = mk_uop(ALU_ADD, SP_REG, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
                    w_u1 = mk_uop(ALU_ADD, SP_REG, w_ra_reg, SP_REG, 32'd4, 1'b0, 1'b0, 1'b1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (r_state == IDLE) && (r_count < 5'(DEPTH));
    assign w_accept = in_valid && in_ready && !flush;
    assign w_pop    = out_ready && (r_count != 5'd0) && !flush;

`ifdef TRANSLATE_SEQ_BYPASS_EN
    assign w_bypass = (r_state == IDLE) && (r_count == 5'd0) && in_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_bypass_take = w_bypass && out_ready;

    always_comb begin
        w_push      = 1'b0;
        w_push_uop  = w_u0;
        w_push_last = !w_expand;
        if (r_state == IDLE) begin
            w_push = w_accept && !w_bypass_take;
        end else begin
            // A full queue can still take U1 in a cycle where the head leaves.
            w_push      = !flush && ((r_count < 5'(DEPTH)) || w_pop);
            w_push_uop  = r_u1;
            w_push_last = 1'b1;
        end
    end

    always_comb begin
        out_valid = (r_count != 5'd0) || w_bypass;
        out_uop   = '0;
        out_last  = 1'b0;
        if (r_count != 5'd0) begin
            out_uop  = r_mem[r_head][55:1];
            out_last = r_mem[r_head][0];
        end else if (w_bypass) begin
            out_uop  = w_u0;
            out_last = !w_expand;
        end
    end

    assign count = r_count;

    // NOTE: queue storage has no reset; occupancy lives in r_count and out_uop is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {w_push_uop, w_push_last};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
            r_u1    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_u1    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (w_pop)  r_head <= ptr_inc(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: ;
            endcase
            case (r_state)
                IDLE: if (w_accept && w_expand) begin
                    r_u1    <= w_u1;
                    r_state <= EXP;
                end
                EXP:  if (w_push) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_translate_seq.sv
// Self-checking bench for translate_seq: directed scenarios plus random traffic against a queue-based model.
module tb_translate_seq;

    localparam int         DEPTH = 4;
    localparam logic [4:0] SP    = 5'd4;
    localparam logic [3:0] ADD   = 4'b0000;
    localparam logic [3:0] ORR   = 4'b0101;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [47:0] inst = '0;
    logic [31:0] next_inst_pc = '0;
    logic [54:0] in_uop = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [54:0] out_uop;
    logic        out_last;
    logic [4:0]  count;

    translate_seq #(.DEPTH(DEPTH), .SP_REG(SP)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode         (mode),
        .inst         (inst),
        .next_inst_pc (next_inst_pc),
        .in_uop       (in_uop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_uop      (out_uop),
        .out_last     (out_last),
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: queued entries and not-yet-queued tail of the current instruction, each {uop, last}.
    logic [55:0] mq[$];
    logic [55:0] mpend[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] mk(input logic [3:0] aluc, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [4:0] rn,
                                       input logic [31:0] imm, input logic m2r,
                                       input logic wm, input logic wr, input logic last);
        return {aluc, ra, rb, rn, imm, m2r, wm, wr, 1'b1, last};
    endfunction

    task automatic expand(output logic [55:0] a, output logic [55:0] b, output bit two);
        logic [4:0] r;
        r   = {1'b0, inst[15:12]};
        two = 1'b1;
        b   = '0;
        a   = {in_uop, 1'b1};
        if (!mode) two = 1'b0;
        else begin
            case (inst[7:4])
                4'hA: begin
                    a = mk(ADD, SP, 5'd0, SP, -32'sd4, 0, 0, 1, 0);
                    b = mk(ADD, SP, r, 5'd0, 32'd0, 0, 1, 0, 1);
                end
                4'hB: begin
                    a = mk(ADD, SP, 5'd0, r, 32'd0, 1, 0, 1, 0);
                    b = mk(ADD, SP, 5'd0, SP, 32'd4, 0, 0, 1, 1);
                end
                4'h8: begin
                    a = mk(ADD, SP, 5'd0, SP, -32'sd4, 0, 0, 1, 0);
                    b = mk(ORR, 5'd0, SP, 5'd0, next_inst_pc, 0, 1, 0, 1);
                end
                4'h9: begin
                    a = mk(ADD, SP, 5'd0, 5'd0, 32'd0, 1, 0, 0, 0);
                    b = mk(ADD, SP, r, SP, 32'd4, 0, 0, 1, 1);
                end
                default: two = 1'b0;
            endcase
        end
    endtask

    function automatic bit model_ready();
        return (mpend.size() == 0) && (mq.size() < DEPTH);
    endfunction

    task automatic compare_outputs(input string tag);
        logic [55:0] head;
        head = (mq.size() != 0) ? mq[0] : 56'd0;
        check({tag, "_in_ready"},  64'(in_ready),  64'(model_ready()));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, "_out_uop"},   64'(out_uop),   64'(head[55:1]));
        check({tag, "_out_last"},  64'(out_last),  64'(head[0]));
        check({tag, "_count"},     64'(count),     64'(mq.size()));
    endtask

    // Called just after a falling edge with inputs settled; returns at the next falling edge.
    task automatic tick(input string tag);
        bit          pop, rdy, dp, two;
        logic [55:0] pv, a, b;
        #1 compare_outputs(tag);
        pop = out_ready && (mq.size() != 0);
        rdy = model_ready();
        dp  = 1'b0;
        pv  = '0;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            mpend.delete();
        end else begin
            if (mpend.size() != 0) begin
                if ((mq.size() < DEPTH) || pop) begin
                    pv = mpend.pop_front();
                    dp = 1'b1;
                end
            end else if (in_valid && rdy) begin
                expand(a, b, two);
                pv = a;
                dp = 1'b1;
                if (two) mpend.push_back(b);
            end
            if (pop) void'(mq.pop_front());
            if (dp)  mq.push_back(pv);
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic m, input logic [15:0] ins, input logic v);
        mode     = m;
        inst     = {32'h0, ins};
        in_valid = v;
        in_uop   = 55'({$urandom(), $urandom()});
    endtask

    logic [54:0] saved;

    initial begin
        // Reset state while clrn is held low.
        @(negedge clk);
        compare_outputs("rst");
        check("rst_count_zero", 64'(count), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // MIPS single micro-op passes through unchanged one cycle later.
        offer(1'b0, 16'h0000, 1'b1);
        out_ready = 1'b1;
        saved = in_uop;
        tick("mips");
        in_valid = 1'b0;
        check("mips_valid", 64'(out_valid), 64'd1);
        check("mips_uop",   64'(out_uop),   64'(saved));
        check("mips_last",  64'(out_last),  64'd1);
        tick("mips_pop");

        // pushl %eax expands into SP decrement then store.
        out_ready = 1'b0;
        offer(1'b1, 16'h00A0, 1'b1);
        tick("push_acc");
        in_valid = 1'b0;
        check("push_in_ready_exp", 64'(in_ready), 64'd0);
        check("push_u0_rn",   64'(out_uop[40:36]), 64'd4);
        check("push_u0_imm",  64'(out_uop[35:4]),  64'hFFFF_FFFC);
        check("push_u0_wreg", 64'(out_uop[1]),     64'd1);
        check("push_u0_last", 64'(out_last),       64'd0);
        tick("push_u1");
        check("push_in_ready_back", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick("push_pop0");
        check("push_u1_rb",   64'(out_uop[45:41]), 64'd0);
        check("push_u1_wmem", 64'(out_uop[2]),     64'd1);
        check("push_u1_last", 64'(out_last),       64'd1);
        tick("push_pop1");

        // Two calls with a stalled consumer fill the queue; head holds still.
        out_ready    = 1'b0;
        next_inst_pc = 32'h100;
        offer(1'b1, 16'h0080, 1'b1);
        tick("call_a0");
        saved = out_uop;
        tick("call_a1");
        check("call_hold", 64'(out_uop), 64'(saved));
        tick("call_b0");
        tick("call_b1");
        in_valid = 1'b0;
        check("call_full_count", 64'(count),    64'd4);
        check("call_full_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick("call_pop0");
        check("call_u1_imm",  64'(out_uop[35:4]), 64'h100);
        check("call_u1_last", 64'(out_last),      64'd1);
        for (int i = 0; i < 3; i++) tick("call_drain");

        // Full queue with U1 pending: push and pop together, then stream through wrap.
        out_ready = 1'b0;
        offer(1'b1, 16'h0080, 1'b1);
        tick("wrap_c0");
        tick("wrap_c1");
        offer(1'b0, 16'h0000, 1'b1);
        tick("wrap_m");
        offer(1'b1, 16'h30A0, 1'b1);
        tick("wrap_p0");
        in_valid = 1'b0;
        check("wrap_full_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        tick("wrap_pushpop");
        check("wrap_same_count", 64'(count), 64'd4);
        for (int i = 0; i < 8; i++) begin
            offer(1'b0, 16'h0000, 1'b1);
            tick("wrap_stream");
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick("wrap_drain");

        // flush while expanding with three entries queued.
        out_ready = 1'b0;
        offer(1'b0, 16'h0000, 1'b1);
        tick("fl_m0");
        offer(1'b0, 16'h0000, 1'b1);
        tick("fl_m1");
        offer(1'b1, 16'h10A0, 1'b1);
        tick("fl_p0");
        check("fl_pre_count", 64'(count), 64'd3);
        flush = 1'b1;
        offer(1'b0, 16'h0000, 1'b1);
        tick("fl_flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_count", 64'(count),     64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        tick("fl_idle0");
        check("fl_no_u1", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a popl expansion.
        offer(1'b1, 16'h20B0, 1'b1);
        tick("rp_acc");
        in_valid = 1'b0;
        #2 clrn = 1'b0;
        #1;
        check("rp_valid", 64'(out_valid), 64'd0);
        check("rp_count", 64'(count),     64'd0);
        check("rp_uop",   64'(out_uop),   64'd0);
        check("rp_last",  64'(out_last),  64'd0);
        mq.delete();
        mpend.delete();
        @(negedge clk);
        #2 clrn = 1'b1;
        @(negedge clk);
        tick("rp_idle");
        out_ready = 1'b1;
        offer(1'b1, 16'h20B0, 1'b1);
        tick("rp2_acc");
        in_valid = 1'b0;
        check("rp2_u0_rn",    64'(out_uop[40:36]), 64'd2);
        check("rp2_u0_m2reg", 64'(out_uop[3]),     64'd1);
        tick("rp2_u1");
        check("rp2_u1_imm",  64'(out_uop[35:4]), 64'd4);
        check("rp2_u1_last", 64'(out_last),      64'd1);
        tick("rp2_done");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ic;
            case ($urandom_range(0, 6))
                0: ic = 4'hA;
                1: ic = 4'hB;
                2: ic = 4'h8;
                3: ic = 4'h9;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            offer(1'($urandom_range(0, 1)), {4'($urandom()), 4'($urandom()), ic, 4'($urandom())},
                  ($urandom_range(0, 9) < 7));
            next_inst_pc = $urandom();
            out_ready    = ($urandom_range(0, 9) < 6);
            flush        = ($urandom_range(0, 39) == 0);
            tick("rnd");
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick("final_drain");
        check("final_empty", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
